// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned XLEN          = 32;
  localparam logic [XLEN-1:0] NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Entry storage for ifetch_queue: synchronous write, combinational head read, flush.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  ifq_entry_t                   wdata,
  input  logic                         pop,
  output ifq_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  ifq_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage array carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: single-outstanding fetch FSM feeding ifq_fifo toward IF/ID.
// Macro IFQ_BYPASS_EN: a response reaching an empty queue is presented on out_* the same cycle.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  input  logic        out_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  ifq_state_e    state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  ifq_entry_t    head;
  ifq_entry_t    push_entry;
  logic          active;
  logic          queue_empty;
  logic          accept;
  logic          rsp_wait;
  logic          bypass_hit;
  logic          fifo_push;
  logic          fifo_pop;

  // Redirect and reset override every handshake in their cycle.
  assign active      = !reset && !redirect;
  assign queue_empty = (count == '0);

  assign imem_req  = active && (state == IDLE) && (count < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign rsp_wait  = active && (state == WAIT) && imem_rvalid;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = rsp_wait && queue_empty && out_ready;
`else
  assign bypass_hit = 1'b0;
`endif

  // fetch_pc already advanced at accept, so in WAIT it equals the request address + 4.
  assign push_entry = '{instr: imem_rdata, pc4: fetch_pc};
  assign fifo_push  = rsp_wait && !bypass_hit;
  assign fifo_pop   = active && !queue_empty && out_ready;

  assign out_valid = active && (!queue_empty || bypass_hit);
  assign out_instr = !out_valid ? NOP   : (queue_empty ? imem_rdata : head.instr);
  assign out_pc4   = !out_valid ? '0    : (queue_empty ? fetch_pc   : head.pc4);

  // Fetch FSM; a redirect with a response still in flight waits it out in DROP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      state    <= ((state != IDLE) && !imem_rvalid) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WAIT;
            fetch_pc <= pc_next(fetch_pc);
          end
        end
        WAIT, DROP: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .head  (head),
    .count (count)
  );

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port redirect, input, 1, branch/jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc, input, 32, new fetch address.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request valid.
REQ-008 SHALL have port imem_addr, output, 32, request word address.
REQ-009 SHALL have port imem_ready, input, 1, request accepted when imem_req && imem_ready.
REQ-010 SHALL have port imem_rvalid, input, 1, response data valid (1+ cycles after accept).
REQ-011 SHALL have port imem_rdata, input, 32, instruction word.
REQ-012 SHALL have port out_valid, output, 1, out_instr/out_pc4 valid to IF/ID register.
REQ-013 SHALL have port out_instr, output, 32, head instruction.
REQ-014 SHALL have port out_pc4, output, 32, head instruction address + 4.
REQ-015 SHALL have port out_ready, input, 1, pipeline write enable (0 = stall); pop when out_valid && out_ready.

Function
REQ-016 SHALL hold fetch_pc; increment by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) on each accepted request.
REQ-017 SHALL keep at most one request outstanding.
REQ-018 SHALL assert imem_req only in IDLE when count + 0 < DEPTH and redirect == 0; imem_addr = fetch_pc.
REQ-019 SHALL implement FSM IDLE -> WAIT on accept; WAIT -> IDLE on imem_rvalid; WAIT -> DROP on redirect; DROP -> IDLE on imem_rvalid.
REQ-020 SHALL push {imem_rdata, addr+4} into FIFO on imem_rvalid in WAIT; discard imem_rvalid in DROP or IDLE.
REQ-021 SHALL allow push and pop in the same cycle at any occupancy, including full (count unchanged).
REQ-022 SHALL drive out_valid = (count != 0); out_instr/out_pc4 = head entry; out_instr = 0 (NOP) when empty.
REQ-023 SHALL hold head stable while out_valid && !out_ready.
REQ-024 SHALL on redirect: empty FIFO, load fetch_pc = redirect_pc, suppress that cycle's push, pop and imem_req; redirect has priority over all other events.
REQ-025 SHALL, in the redirect cycle, drive out_valid = 0.
REQ-026 SHALL yield min latency 2 cycles from accept (1-cycle memory) to out_valid.

Reset
REQ-027 SHALL on reset: fetch_pc = RESET_PC, state IDLE, count/pointers 0, out_valid 0, imem_req 0, out_instr 0, out_pc4 0.
REQ-028 SHALL, on reset mid-request, enter DROP if rvalid still pending is not tracked: after reset, state IDLE and any later stray imem_rvalid in IDLE is ignored.

Configuration
REQ-029 SHALL support macro IFQ_BYPASS_EN: defined -> when FIFO empty, state WAIT, imem_rvalid && out_ready, response presented same cycle on out_* and not stored (latency 1); undefined -> response always stored, visible next cycle.

Structure
REQ-030 SHALL place FSM state enum (IDLE/WAIT/DROP), NOP constant, default DEPTH in shared package ifq_pkg.
REQ-031 SHALL implement storage as sub-module ifq_fifo (sync write, combinational head read, flush input).

Verification
REQ-032 Reset, 1-cycle memory, out_ready=1 -> imem_addr 0,4,8,...; out_pc4 4,8,12 in order, no gaps after fill.
REQ-033 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries stored, imem_req deasserts, head pc4=4 stable; release -> 4,8,12,16,20 in order.
REQ-034 redirect=1, redirect_pc=32'h0000_0100 while WAIT -> late response dropped, out_valid 0, next imem_addr 0x100, next out_pc4 0x104.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc4 FFFF_FFFC, 0000_0000.
REQ-036 Full FIFO with simultaneous pop and push -> count stays 4, order preserved; with IFQ_BYPASS_EN, empty FIFO + rvalid + out_ready -> out_valid same cycle.
REQ-037 reset asserted in WAIT with imem_rvalid one cycle later -> response ignored, out_valid 0, imem_addr = RESET_PC.
